// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned DEF_PC_WIDTH    = 10;
  localparam int unsigned DEF_INSTR_WIDTH = 16;
  localparam int unsigned RJMP_K_WIDTH    = 12;
  localparam int unsigned BR_K_WIDTH      = 7;
  localparam int unsigned RESET_VECTOR    = 0;
  localparam logic [15:0] NOP_WORD        = 16'h0000;

  // Encoded as {pend_valid, instr_valid}.
  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_FILL = 2'b10,
    ST_RUN  = 2'b11
  } fill_state_e;

endpackage

// File: rtl/fetch_unit_branch_target_calc.sv
// Relative jump target: instr_pc + 1 + sign-extended RJMP/branch offset, modulo 2^PC_WIDTH.
module fetch_unit_branch_target_calc
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH = DEF_PC_WIDTH
) (
  input  logic [PC_WIDTH-1:0]     instr_pc,
  input  logic [RJMP_K_WIDTH-1:0] redirect_offset,
  input  logic                    redirect_short,
  output logic [PC_WIDTH-1:0]     target_c
);

  logic [PC_WIDTH-1:0] offs;

  // Sized casts of signed operands sign-extend (or truncate) to the PC width.
  always_comb begin
    offs = '0;
    if (redirect_short) begin
      offs = PC_WIDTH'($signed(redirect_offset[BR_K_WIDTH-1:0]));
    end else begin
      offs = PC_WIDTH'($signed(redirect_offset));
    end
    target_c = instr_pc + PC_WIDTH'(1) + offs;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads synchronous program memory,
// feeds the decoder's instruction register, applies relative redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic                    redirect_short,
  input  logic [RJMP_K_WIDTH-1:0] redirect_offset,
  output logic [PC_WIDTH-1:0]     imem_addr,
  output logic                    imem_en,
  input  logic [INSTR_WIDTH-1:0]  imem_rdata,
  output logic [INSTR_WIDTH-1:0]  instruction,
  output logic [PC_WIDTH-1:0]     instr_pc,
  output logic                    instr_valid
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_WORD);
  localparam logic [PC_WIDTH-1:0]    RST_PC = PC_WIDTH'(RESET_VECTOR);

  fill_state_e         state;
  fill_state_e         state_next;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] pend_pc;
  logic                pend_valid;
  logic [PC_WIDTH-1:0] target_c;

  assign pend_valid  = state[1];
  assign instr_valid = state[0];
  assign imem_addr   = fetch_pc;
  assign imem_en     = !stall;

  fetch_unit_branch_target_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_branch_target_calc (
    .instr_pc        (instr_pc),
    .redirect_offset (redirect_offset),
    .redirect_short  (redirect_short),
    .target_c        (target_c)
  );

  // Pipeline fill progression on a plain sequential cycle.
  always_comb begin
    state_next = ST_BOOT;
    unique case (state)
      ST_BOOT:         state_next = ST_FILL;
      ST_FILL, ST_RUN: state_next = ST_RUN;
      default:         state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      fetch_pc    <= RST_PC;
      pend_pc     <= RST_PC;
      instruction <= NOP;
      instr_pc    <= RST_PC;
    end else if (!stall) begin
      if (redirect) begin
        // Drop both wrong-path words; decoder sees a NOP bubble.
        state       <= ST_BOOT;
        fetch_pc    <= target_c;
        instruction <= NOP;
      end else begin
        state       <= state_next;
        instruction <= pend_valid ? imem_rdata : NOP;
        instr_pc    <= pend_pc;
        pend_pc     <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a synchronous memory model mem[i] = 16'hE000 + i.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic        redirect_short;
  logic [11:0] redirect_offset;
  logic [9:0]  imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instruction;
  logic [9:0]  instr_pc;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_short  (redirect_short),
    .redirect_offset (redirect_offset),
    .imem_addr       (imem_addr),
    .imem_en         (imem_en),
    .imem_rdata      (imem_rdata),
    .instruction     (instruction),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 16'hE000 + 16'(imem_addr);
  end

  typedef struct {
    logic        st;
    logic        rd;
    logic        sh;
    logic [11:0] off;
    logic        ev;
    int          epc;
    logic [15:0] eins;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, input logic rd, input logic sh,
                              input logic [11:0] off, input logic ev, input int epc);
    vec_t v;
    v.st   = st;
    v.rd   = rd;
    v.sh   = sh;
    v.off  = off;
    v.ev   = ev;
    v.epc  = epc;
    v.eins = ev ? (16'hE000 + 16'(epc)) : 16'h0000;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_short = 1'b0;
    redirect_offset = 12'h000;

    // Cycle-by-cycle table; each row's inputs are applied before the edge it checks.
    add(0, 0, 0, 12'h000, 0, 0);
    for (int p = 0; p <= 5; p++) add(0, 0, 0, 12'h000, 1, p);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 12'h000, 1, 5);
    for (int p = 6; p <= 10; p++) add(0, 0, 0, 12'h000, 1, p);
    add(1, 1, 0, 12'h005, 1, 10);      // redirect under stall is ignored
    add(0, 1, 0, 12'h005, 0, 0);       // RJMP +5 from 10 -> 16
    add(0, 0, 0, 12'h000, 0, 0);
    for (int p = 16; p <= 20; p++) add(0, 0, 0, 12'h000, 1, p);
    add(0, 1, 1, 12'hAFC, 0, 0);       // branch -4 from 20 -> 17, junk in [11:7]
    add(0, 0, 0, 12'h000, 0, 0);
    add(0, 0, 0, 12'h000, 1, 17);
    add(0, 0, 0, 12'h000, 1, 18);
    add(0, 1, 0, 12'h3EA, 0, 0);       // 18 + 1 + 1002 -> 1021
    add(0, 0, 0, 12'h000, 0, 0);
    add(0, 0, 0, 12'h000, 1, 1021);
    add(0, 0, 0, 12'h000, 1, 1022);
    add(0, 0, 0, 12'h000, 1, 1023);
    add(0, 0, 0, 12'h000, 1, 0);
    add(0, 1, 0, 12'hFFE, 0, 0);       // 0 + 1 - 2 -> 1023
    add(0, 0, 0, 12'h000, 0, 0);
    add(0, 0, 0, 12'h000, 1, 1023);
    add(0, 0, 0, 12'h000, 1, 0);
    add(0, 0, 0, 12'h000, 1, 1);

    #2;
    check("reset instr_valid", 32'(instr_valid), 32'd0);
    check("reset instruction", 32'(instruction), 32'h0);
    check("reset instr_pc", 32'(instr_pc), 32'd0);
    check("reset imem_addr", 32'(imem_addr), 32'd0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].st;
      redirect = vecs[i].rd;
      redirect_short = vecs[i].sh;
      redirect_offset = vecs[i].off;
      if (vecs[i].rd && !vecs[i].st) begin
        checks++;
        if (!instr_valid) begin
          errors++;
          $display("FAIL row%0d redirect_legal: instr_valid %0d required 1", i, instr_valid);
        end
      end
      tick();
      check($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
      check($sformatf("row%0d instruction", i), 32'(instruction), 32'(vecs[i].eins));
      check($sformatf("row%0d imem_en", i), 32'(imem_en), 32'(!vecs[i].st));
      if (vecs[i].ev) check($sformatf("row%0d instr_pc", i), 32'(instr_pc), 32'(vecs[i].epc));
    end

    // Asynchronous reset between edges with stall and redirect held.
    stall = 1'b1;
    redirect = 1'b1;
    redirect_offset = 12'h005;
    #1;
    check("stall imem_en comb", 32'(imem_en), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async instr_valid", 32'(instr_valid), 32'd0);
    check("async instruction", 32'(instruction), 32'h0);
    check("async instr_pc", 32'(instr_pc), 32'd0);
    check("async imem_addr", 32'(imem_addr), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("post-reset stall valid", 32'(instr_valid), 32'd0);
    check("post-reset stall addr", 32'(imem_addr), 32'd0);
    stall = 1'b0;
    redirect = 1'b0;
    tick();
    check("restart e1 valid", 32'(instr_valid), 32'd0);
    check("restart e1 addr", 32'(imem_addr), 32'd1);
    tick();
    check("restart e2 valid", 32'(instr_valid), 32'd1);
    check("restart e2 instruction", 32'(instruction), 32'hE000);
    check("restart e2 instr_pc", 32'(instr_pc), 32'd0);
    tick();
    check("restart e3 instruction", 32'(instruction), 32'hE001);
    check("restart e3 instr_pc", 32'(instr_pc), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
